// File: rtl/nd120_front_panel.sv
// ND-120 front panel: synchronised/debounced buttons with short/long press pulses,
// per-LED mode drive (off/on/blink/status) and a stretched active-low CPU reset.

module nd120_front_panel #(
  parameter int N_BTN             = 2,
  parameter int N_LED             = 6,
  parameter int DEBOUNCE_CYCLES   = 393216,
  parameter int LONG_PRESS_CYCLES = 39321600,
  parameter int BLINK_DIV         = 9830400,
  parameter int RST_HOLD          = 1024,
  parameter bit RST_BTN_EN        = 1'b1,
  parameter bit LED_ACTIVE_LOW    = 1'b1
) (
  input  logic                 sysclk,
  input  logic                 sys_rst,
  input  logic [N_BTN-1:0]     btn_n,
  input  logic [2*N_LED-1:0]   led_mode,
  input  logic [N_LED-1:0]     led_status,
  output logic [N_BTN-1:0]     btn_level,
  output logic [N_BTN-1:0]     btn_press,
  output logic [N_BTN-1:0]     btn_short,
  output logic [N_BTN-1:0]     btn_long,
  output logic [N_LED-1:0]     led,
  output logic                 cpu_rst_n
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int RW = $clog2(RST_HOLD + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE   = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [RW-1:0] RST_LOAD   = RW'(RST_HOLD);

  logic [N_BTN-1:0]          sync1_q, sync2_q;
  logic [N_BTN-1:0]          acc_q, acc_d;
  logic [N_BTN-1:0][DW-1:0]  db_cnt_q, db_cnt_d;
  logic [N_BTN-1:0][HW-1:0]  hold_q, hold_d;
  logic [N_BTN-1:0]          level_q, level_d;
  logic [N_BTN-1:0]          press_q, press_d;
  logic [N_BTN-1:0]          short_q, short_d;
  logic [N_BTN-1:0]          long_q, long_d;
  logic [BW-1:0]             blink_cnt_q, blink_cnt_d;
  logic                      blink_q, blink_d;
  logic [N_LED-1:0]          led_q, led_d;
  logic [RW-1:0]             rst_cnt_q, rst_cnt_d;
  logic                      rst_n_q;

  // acc_q holds the accepted active-low level; the pressed view lags it by one register
  assign level_d = ~acc_q;
  assign press_d = level_d & ~level_q;

  always_comb begin
    acc_d    = acc_q;
    db_cnt_d = '0;
    hold_d   = '0;
    long_d   = '0;
    short_d  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2_q[i] != acc_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) acc_d[i] = ~acc_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
      end
      if (level_q[i]) hold_d[i] = (hold_q[i] == HOLD_MAX) ? hold_q[i] : hold_q[i] + HW'(1);
      // A release landing on the threshold cycle wins: short, never long
      long_d[i]  = level_q[i] & level_d[i] & (hold_q[i] == HOLD_PRE);
      short_d[i] = level_q[i] & ~level_d[i] & (hold_q[i] != HOLD_MAX);
    end
  end

  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q + BW'(1);
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_comb begin
    led_d = '0;
    for (int j = 0; j < N_LED; j++) begin
      case (led_mode[2*j +: 2])
        2'b00:   led_d[j] = 1'b0;
        2'b01:   led_d[j] = 1'b1;
        2'b10:   led_d[j] = blink_q;
        default: led_d[j] = led_status[j];
      endcase
      led_d[j] = led_d[j] ^ LED_ACTIVE_LOW;
    end
  end

  // Re-trigger reloads rather than extends the remaining hold
  always_comb begin
    rst_cnt_d = (rst_cnt_q == '0) ? '0 : rst_cnt_q - RW'(1);
    if (RST_BTN_EN && long_q[0]) rst_cnt_d = RST_LOAD;
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      acc_q       <= '1;
      db_cnt_q    <= '0;
      hold_q      <= '0;
      level_q     <= '0;
      press_q     <= '0;
      short_q     <= '0;
      long_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      led_q       <= {N_LED{LED_ACTIVE_LOW}};
      rst_cnt_q   <= RST_LOAD;
      rst_n_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_n;
      sync2_q     <= sync1_q;
      acc_q       <= acc_d;
      db_cnt_q    <= db_cnt_d;
      hold_q      <= hold_d;
      level_q     <= level_d;
      press_q     <= press_d;
      short_q     <= short_d;
      long_q      <= long_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      led_q       <= led_d;
      rst_cnt_q   <= rst_cnt_d;
      rst_n_q     <= (rst_cnt_d == '0);
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;
  assign btn_short = short_q;
  assign btn_long  = long_q;
  assign led       = led_q;
  assign cpu_rst_n = rst_n_q;

endmodule
